// File: rtl/alu_exec_unit.sv
// Execute-stage slice of the 16-bit TSC CPU.
// Imm extend, ALU decode, operand mux, ALU, branch test, result/flag register.
module alu_exec_unit (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [15:0] instr,
  input  logic [15:0] read_out1,
  input  logic [15:0] read_out2,
  input  logic        alu_src,
  input  logic        en,
  output logic [15:0] extend_imm,
  output logic [2:0]  func_code,
  output logic [15:0] alu_result,
  output logic        branch_cond,
  output logic [15:0] result_q,
  output logic [2:0]  flags_q
);

  localparam logic [3:0] OP_BNE = 4'd0;
  localparam logic [3:0] OP_BEQ = 4'd1;
  localparam logic [3:0] OP_BGZ = 4'd2;
  localparam logic [3:0] OP_BLZ = 4'd3;
  localparam logic [3:0] OP_ADI = 4'd4;
  localparam logic [3:0] OP_ORI = 4'd5;
  localparam logic [3:0] OP_LHI = 4'd6;
  localparam logic [3:0] OP_LWD = 4'd7;
  localparam logic [3:0] OP_SWD = 4'd8;
  localparam logic [3:0] OP_RTY = 4'd15;

  localparam logic [2:0] F_ADD = 3'd0;
  localparam logic [2:0] F_SUB = 3'd1;
  localparam logic [2:0] F_AND = 3'd2;
  localparam logic [2:0] F_OR  = 3'd3;
  localparam logic [2:0] F_NOT = 3'd4;
  localparam logic [2:0] F_TCP = 3'd5;
  localparam logic [2:0] F_SHL = 3'd6;
  localparam logic [2:0] F_SHR = 3'd7;

  logic [3:0]  opcode;
  logic [7:0]  imm;
  logic [5:0]  func;
  logic [15:0] op_a;
  logic [15:0] op_b;
  logic        overflow;
  logic        unused_bits;

  assign opcode      = instr[15:12];
  assign imm         = instr[7:0];
  assign func        = instr[5:0];
  assign unused_bits = &{1'b0, instr[11:8]};

  // Immediate extension per opcode
  always_comb begin
    extend_imm = {8'h00, imm};
    unique case (opcode)
      OP_ADI, OP_LWD, OP_SWD,
      OP_BNE, OP_BEQ, OP_BGZ, OP_BLZ:
        extend_imm = {{8{imm[7]}}, imm};
      OP_LHI:
        extend_imm = {imm, 8'h00};
      default:
        extend_imm = {8'h00, imm};
    endcase
  end

  // ALU operation decode
  always_comb begin
    func_code = F_ADD;
    unique case (opcode)
      OP_RTY:
        func_code = (func[5:3] == 3'd0) ? func[2:0] : F_ADD;
      OP_ORI:
        func_code = F_OR;
      OP_BNE, OP_BEQ, OP_BGZ, OP_BLZ:
        func_code = F_SUB;
      default:
        func_code = F_ADD;
    endcase
  end

  assign op_a = read_out1;
  assign op_b = alu_src ? extend_imm : read_out2;

  // 16-bit ALU with signed overflow detection for ADD/SUB
  always_comb begin
    alu_result = 16'h0000;
    overflow   = 1'b0;
    unique case (func_code)
      F_ADD: begin
        alu_result = op_a + op_b;
        overflow   = (op_a[15] == op_b[15]) &&
                     (alu_result[15] != op_a[15]);
      end
      F_SUB: begin
        alu_result = op_a - op_b;
        overflow   = (op_a[15] != op_b[15]) &&
                     (alu_result[15] != op_a[15]);
      end
      F_AND: alu_result = op_a & op_b;
      F_OR:  alu_result = op_a | op_b;
      F_NOT: alu_result = ~op_a;
      F_TCP: alu_result = ~op_a + 16'd1;
      F_SHL: alu_result = {op_a[14:0], 1'b0};
      F_SHR: alu_result = {op_a[15], op_a[15:1]};
      default: alu_result = 16'h0000;
    endcase
  end

  // Branch test always on the raw register operands
  always_comb begin
    branch_cond = 1'b0;
    unique case (opcode)
      OP_BNE: branch_cond = (read_out1 != read_out2);
      OP_BEQ: branch_cond = (read_out1 == read_out2);
      OP_BGZ: branch_cond = !read_out1[15] &&
                            (read_out1 != 16'h0000);
      OP_BLZ: branch_cond = read_out1[15];
      default: branch_cond = 1'b0;
    endcase
  end

  // Capture result and {ovf, neg, zero} when enabled
  always_ff @(posedge clk or posedge reset_n) begin
    if (reset_n) begin
      result_q <= 16'h0000;
      flags_q  <= 3'b000;
    end else if (en) begin
      result_q <= alu_result;
      flags_q  <= {overflow, alu_result[15],
                   alu_result == 16'h0000};
    end
  end

endmodule

// File: tb/tb_alu_exec_unit.sv
// Self-checking bench for alu_exec_unit.
// Directed plan vectors plus random vectors against an integer model.
module tb_alu_exec_unit;

  logic        clk;
  logic        reset_n;
  logic [15:0] instr;
  logic [15:0] read_out1;
  logic [15:0] read_out2;
  logic        alu_src;
  logic        en;
  logic [15:0] extend_imm;
  logic [2:0]  func_code;
  logic [15:0] alu_result;
  logic        branch_cond;
  logic [15:0] result_q;
  logic [2:0]  flags_q;

  int n_tests = 0;
  int n_fail  = 0;

  alu_exec_unit dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .instr       (instr),
    .read_out1   (read_out1),
    .read_out2   (read_out2),
    .alu_src     (alu_src),
    .en          (en),
    .extend_imm  (extend_imm),
    .func_code   (func_code),
    .alu_result  (alu_result),
    .branch_cond (branch_cond),
    .result_q    (result_q),
    .flags_q     (flags_q)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Reference: signed integer arithmetic straight from the rules
  function automatic void model(
    input  logic [15:0] ins,
    input  logic [15:0] a,
    input  logic [15:0] b,
    input  logic        src,
    output logic [15:0] ext,
    output logic [2:0]  fc,
    output logic [15:0] res,
    output logic [2:0]  flg,
    output logic        br);
    int op, im, fn, sa, sb, s, sr;
    logic [15:0] bv;
    logic ov;
    op = int'(ins[15:12]);
    im = int'(ins[7:0]);
    fn = int'(ins[5:0]);
    if (op inside {0, 1, 2, 3, 4, 7, 8})
      ext = 16'(im >= 128 ? im - 256 : im);
    else if (op == 6)
      ext = 16'(im * 256);
    else
      ext = 16'(im);
    if (op == 15 && fn < 8) fc = 3'(fn);
    else if (op == 5)       fc = 3'd3;
    else if (op <= 3)       fc = 3'd1;
    else                    fc = 3'd0;
    bv = src ? ext : b;
    sa = int'($signed(a));
    sb = int'($signed(bv));
    ov = 1'b0;
    case (fc)
      3'd0: begin s = sa + sb; ov = (s > 32767) || (s < -32768); end
      3'd1: begin s = sa - sb; ov = (s > 32767) || (s < -32768); end
      3'd2: s = int'(a & bv);
      3'd3: s = int'(a | bv);
      3'd4: s = 65535 - int'(a);
      3'd5: s = -sa;
      3'd6: s = sa * 2;
      default: s = sa >>> 1;
    endcase
    res = 16'(s);
    sr  = int'($signed(res));
    flg = {ov, sr < 0, sr == 0};
    case (op)
      0: br = (a != b);
      1: br = (a == b);
      2: br = (sa > 0);
      3: br = (sa < 0);
      default: br = 1'b0;
    endcase
  endfunction

  logic [15:0] m_ext, m_res;
  logic [2:0]  m_fc, m_flg;
  logic        m_br;
  logic [15:0] q_res;
  logic [2:0]  q_flg;

  // Drive one vector mid-cycle, check comb outputs, then clock it in
  task automatic run(input string tag,
                     input logic [15:0] ins,
                     input logic [15:0] a,
                     input logic [15:0] b,
                     input logic src,
                     input logic e);
    @(negedge clk);
    instr = ins; read_out1 = a; read_out2 = b;
    alu_src = src; en = e;
    #1;
    model(ins, a, b, src, m_ext, m_fc, m_res, m_flg, m_br);
    check({tag, ".ext"}, 32'(extend_imm), 32'(m_ext));
    check({tag, ".fc"},  32'(func_code),  32'(m_fc));
    check({tag, ".res"}, 32'(alu_result), 32'(m_res));
    check({tag, ".br"},  32'(branch_cond), 32'(m_br));
    if (e) begin
      q_res = m_res;
      q_flg = m_flg;
    end
    @(posedge clk);
    #1;
    check({tag, ".rq"}, 32'(result_q), 32'(q_res));
    check({tag, ".fq"}, 32'(flags_q),  32'(q_flg));
  endtask

  localparam logic [15:0] EDGE [6] =
    '{16'h0000, 16'h0001, 16'h7FFF, 16'h8000, 16'hFFFF, 16'h8001};

  function automatic logic [15:0] pick();
    if ($urandom_range(0, 2) == 0)
      return EDGE[$urandom_range(0, 5)];
    return 16'($urandom);
  endfunction

  initial begin
    logic [15:0] ins;
    logic [5:0]  fn;
    int k;
    reset_n = 1'b1;
    instr = 16'h0000; read_out1 = 16'h0000; read_out2 = 16'h0000;
    alu_src = 1'b0; en = 1'b1;
    q_res = 16'h0000; q_flg = 3'b000;
    #2;
    check("rst.rq", 32'(result_q), 32'h0);
    check("rst.fq", 32'(flags_q), 32'h0);
    @(negedge clk);
    reset_n = 1'b0;

    // Directed plan vectors with literal expectations
    run("adi", 16'h44FF, 16'h0005, 16'h0000, 1'b1, 1'b1);
    check("adi.lit_ext", 32'(extend_imm), 32'hFFFF);
    check("adi.lit_rq", 32'(result_q), 32'h0004);
    check("adi.lit_fq", 32'(flags_q), 32'h0);
    run("ori", 16'h5080, 16'h0001, 16'h0000, 1'b1, 1'b1);
    check("ori.lit", 32'(alu_result), 32'h0081);
    run("lhi", 16'h6012, 16'h0000, 16'h0000, 1'b1, 1'b1);
    check("lhi.lit", 32'(extend_imm), 32'h1200);
    for (int f = 0; f < 8; f++) begin
      logic [15:0] sweep [8];
      sweep = '{16'h8004, 16'h7FFE, 16'h0001, 16'h8003,
                16'h7FFE, 16'h7FFF, 16'h0002, 16'hC000};
      run($sformatf("rt%0d", f), 16'hF000 | 16'(f),
          16'h8001, 16'h0003, 1'b0, 1'b1);
      check($sformatf("rt%0d.lit", f), 32'(alu_result), 32'(sweep[f]));
    end
    run("add_ov", 16'hF000, 16'h7FFF, 16'h0001, 1'b0, 1'b1);
    check("add_ov.lit", 32'(flags_q), 32'h6);
    run("sub_ov", 16'hF001, 16'h8000, 16'h0001, 1'b0, 1'b1);
    check("sub_ov.lit", 32'(flags_q[2]), 32'h1);
    run("sub_z", 16'hF001, 16'h0005, 16'h0005, 1'b0, 1'b1);
    check("sub_z.lit", 32'(flags_q[0]), 32'h1);
    run("beq", 16'h1000, 16'h1234, 16'h1234, 1'b0, 1'b1);
    check("beq.lit", 32'(branch_cond), 32'h1);
    run("bne", 16'h0000, 16'h1234, 16'h1234, 1'b0, 1'b1);
    check("bne.lit", 32'(branch_cond), 32'h0);
    run("bgz_n", 16'h2000, 16'h8000, 16'h0000, 1'b0, 1'b1);
    check("bgz_n.lit", 32'(branch_cond), 32'h0);
    run("blz_n", 16'h3000, 16'h8000, 16'h0000, 1'b0, 1'b1);
    check("blz_n.lit", 32'(branch_cond), 32'h1);
    run("bgz_z", 16'h2000, 16'h0000, 16'h0000, 1'b0, 1'b1);
    check("bgz_z.lit", 32'(branch_cond), 32'h0);
    run("jmp", 16'h9000, 16'h1234, 16'h1234, 1'b1, 1'b1);
    check("jmp.lit", 32'(branch_cond), 32'h0);
    run("jpr", 16'hF019, 16'h0010, 16'h0020, 1'b0, 1'b1);

    // Asynchronous reset, hold under reset, resume, enable hold
    run("cap", 16'hF000, 16'h1234, 16'h0000, 1'b0, 1'b1);
    check("cap.lit", 32'(result_q), 32'h1234);
    @(negedge clk);
    #2;
    reset_n = 1'b1;
    #1;
    check("arst.rq", 32'(result_q), 32'h0);
    check("arst.fq", 32'(flags_q), 32'h0);
    instr = 16'hF000; read_out1 = 16'h8000; read_out2 = 16'h8000;
    en = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check("rsthold.rq", 32'(result_q), 32'h0);
    check("rsthold.fq", 32'(flags_q), 32'h0);
    @(negedge clk);
    reset_n = 1'b0;
    q_res = 16'h0000; q_flg = 3'b000;
    run("resume", 16'hF000, 16'h1234, 16'h0000, 1'b0, 1'b1);
    check("resume.lit", 32'(result_q), 32'h1234);
    run("hold", 16'hF000, 16'h0001, 16'h0001, 1'b0, 1'b0);
    run("hold2", 16'hF001, 16'h0005, 16'h0005, 1'b0, 1'b0);
    check("hold.lit", 32'(result_q), 32'h1234);

    // Random sweep
    for (int i = 0; i < 400; i++) begin
      k = $urandom_range(0, 15);
      fn = ($urandom_range(0, 4) == 0) ? 6'($urandom) :
                                         6'($urandom_range(0, 7));
      ins = {4'(k), 4'($urandom), 8'($urandom)};
      if (k == 15) ins[5:0] = fn;
      run($sformatf("rnd%0d", i), ins, pick(), pick(),
          1'($urandom), ($urandom_range(0, 3) != 0));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
